sinogram_ram_arbiter: RTL and testbench



---
 rtl/sinogram_ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sinogram_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sinogram_ram_arbiter.sv
// Arbitrates the single-port sinogram RAM between host sample writes and filter-side reads.
// Define SG_ARB_TURNAROUND_EN to insert a one-cycle bubble whenever the access direction flips.
module sinogram_ram_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 12,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_WR_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam logic [3:0] MAX_WAIT = 4'(MAX_WR_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
`ifdef SG_ARB_TURNAROUND_EN
    , TURN = 2'd3
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              wr_wait_q, wr_wait_d;
  logic [RAM_LATENCY:0]    rd_pipe_q, rd_pipe_d;
  logic                    ram_en_q, ram_en_d;
  logic                    ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    force_wr, want_rd, want_wr;
  logic                    grant_rd, grant_wr;
`ifdef SG_ARB_TURNAROUND_EN
  state_t                  pend_q, pend_d;
  logic                    turn;
`endif

  // Reads win unless the write has been denied MAX_WR_WAIT cycles in a row.
  always_comb begin
    force_wr = wr_req && (wr_wait_q == MAX_WAIT);
    want_rd  = rd_req && !force_wr;
    want_wr  = wr_req && !want_rd;
    grant_rd = want_rd;
    grant_wr = want_wr;
    state_d  = IDLE;
`ifdef SG_ARB_TURNAROUND_EN
    turn   = 1'b0;
    pend_d = pend_q;
    if ((state_q == RD && want_wr) || (state_q == WR && want_rd)) begin
      turn     = 1'b1;
      grant_rd = 1'b0;
      grant_wr = 1'b0;
    end
`endif
    if (!reset_n) begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
    end

    if (grant_rd) begin
      state_d = RD;
    end else if (grant_wr) begin
      state_d = WR;
`ifdef SG_ARB_TURNAROUND_EN
    end else if (turn) begin
      state_d = TURN;
      pend_d  = want_wr ? WR : RD;
    end else if (state_q == TURN) begin
      state_d = pend_q;
`endif
    end

    if (wr_req && !grant_wr) begin
      wr_wait_d = (wr_wait_q == MAX_WAIT) ? wr_wait_q : wr_wait_q + 4'd1;
    end else begin
      wr_wait_d = 4'd0;
    end

    ram_en_d    = grant_rd || grant_wr;
    ram_we_d    = grant_wr;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (grant_wr) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
    end else if (grant_rd) begin
      ram_addr_d  = rd_addr;
      ram_wdata_d = '0;
    end

    rd_pipe_d = {rd_pipe_q[RAM_LATENCY-1:0], grant_rd};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_wait_q   <= 4'd0;
      rd_pipe_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef SG_ARB_TURNAROUND_EN
      pend_q      <= IDLE;
`endif
    end else begin
      state_q     <= state_d;
      wr_wait_q   <= wr_wait_d;
      rd_pipe_q   <= rd_pipe_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef SG_ARB_TURNAROUND_EN
      pend_q      <= pend_d;
`endif
    end
  end

  assign rd_ack        = grant_rd;
  assign wr_ack        = grant_wr;
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign rd_data       = ram_rdata;
  assign rd_data_valid = rd_pipe_q[RAM_LATENCY];
  assign busy          = (|rd_pipe_q) || ram_en_q;

endmodule

// File: tb/tb_sinogram_ram_arbiter.sv
// Self-checking bench for sinogram_ram_arbiter: directed scenarios plus random traffic
// compared every cycle against a cycle-stamped behavioural model.
module tb_sinogram_ram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 12;
  localparam int LAT  = 2;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack, rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sinogram_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT), .MAX_WR_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  // RAM stand-in: returns addr+100 LAT cycles after the command appears.
  logic [AW-1:0] addr_pipe [0:LAT-1];
  always @(posedge clk) begin
    addr_pipe[0] <= ram_addr;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign ram_rdata = DW'(addr_pipe[LAT-1] + 16'd100);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rr, input logic [AW-1:0] ra,
                               input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd_req  = rr;
    rd_addr = ra;
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: expected reads are kept as (due cycle, data) entries.
  typedef struct { int due; logic [DW-1:0] data; } rd_exp_t;
  rd_exp_t rq[$];

  initial begin : model
    int            cyc, m_wait, m_last, m_pend;
    bit            m_turned, force_w, want_r, want_w, er, ew, turn, exp_v;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    cyc = 0; m_wait = 0; m_last = 0; m_pend = 0; m_turned = 0;
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      force_w = wr_req && (m_wait == MAXW);
      want_r  = rd_req && !force_w;
      want_w  = wr_req && !want_r;
      er = want_r; ew = want_w; turn = 0;
`ifdef SG_ARB_TURNAROUND_EN
      if (!m_turned && ((m_last == 1 && want_w) || (m_last == 2 && want_r))) begin
        er = 0; ew = 0; turn = 1;
      end
`endif
      if (!reset_n) begin er = 0; ew = 0; end

      checkOutput("rd_ack", rd_ack, er);
      checkOutput("wr_ack", wr_ack, ew);
      checkOutput("ram_en", ram_en, m_en);
      checkOutput("ram_we", ram_we, m_we);
      checkOutput("ram_addr", ram_addr, m_addr);
      checkOutput("ram_wdata", ram_wdata, m_wdata);
      checkOutput("busy", busy, (rq.size() > 0) || m_en);
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      checkOutput("rd_data_valid", rd_data_valid, exp_v);
      if (exp_v) begin
        checkOutput("rd_data", rd_data, rq[0].data);
        void'(rq.pop_front());
      end

      if (!reset_n) begin
        rq.delete();
        m_wait = 0; m_last = 0; m_turned = 0;
        m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      end else begin
        if (er) rq.push_back('{cyc + 1 + LAT, DW'(rd_addr + 16'd100)});
        m_en = er || ew;
        m_we = ew;
        if (ew) begin m_addr = wr_addr; m_wdata = wr_data; end
        else if (er) begin m_addr = rd_addr; m_wdata = '0; end
        m_wait = (wr_req && !ew) ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
        if (er || ew) begin m_last = er ? 1 : 2; m_turned = 0; end
        else if (turn) begin m_turned = 1; m_pend = want_w ? 2 : 1; end
        else if (m_turned) begin m_last = m_pend; m_turned = 0; end
        else m_last = 0;
      end
      cyc++;
    end
  end

  logic [DW-1:0] got[$];
  bit            collect_en = 0;
  always @(negedge clk) if (collect_en && rd_data_valid) got.push_back(rd_data);

  initial begin : stim
    string exp_pat;
    bit    saw_r, saw_w;
    logic [7:0] code;
    reset_n = 1'b0;
    applyStimulus(1'b1, 16'd5, 1'b0, '0, '0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_rd_ack", rd_ack, 0);
      checkOutput("reset_ram_en", ram_en, 0);
      checkOutput("reset_valid", rd_data_valid, 0);
      checkOutput("reset_busy", busy, 0);
      step();
    end
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("first_rd_ack", rd_ack, 1);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (5) step();

    got.delete();
    collect_en = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, AW'(10 + i), 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("stream_rd_ack", rd_ack, 1);
      if (i > 0) checkOutput("stream_ram_addr", ram_addr, 10 + i - 1);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("stream_ram_addr", ram_addr, 14);
    repeat (6) step();
    collect_en = 0;
    checkOutput("stream_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++) checkOutput("stream_rd_data", got[k], 110 + k);

    applyStimulus(1'b0, '0, 1'b1, 16'h20, 12'h5A5);
    @(negedge clk);
    checkOutput("write_ack", wr_ack, 1);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("write_ram_en", ram_en, 1);
    checkOutput("write_ram_we", ram_we, 1);
    checkOutput("write_ram_addr", ram_addr, 16'h20);
    checkOutput("write_ram_wdata", ram_wdata, 12'h5A5);
    checkOutput("write_no_valid", rd_data_valid, 0);
    repeat (3) step();

    applyStimulus(1'b0, '0, 1'b1, 16'h21, 12'h0AB);
    @(negedge clk);
    checkOutput("turn_wr_ack", wr_ack, 1);
    step();
    applyStimulus(1'b1, 16'h30, 1'b0, '0, '0);
    @(negedge clk);
`ifdef SG_ARB_TURNAROUND_EN
    checkOutput("turn_rd_withheld", rd_ack, 0);
    step();
    @(negedge clk);
    checkOutput("turn_rd_ack", rd_ack, 1);
    checkOutput("turn_gap_ram_en", ram_en, 0);
`else
    checkOutput("turn_rd_ack", rd_ack, 1);
`endif
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (5) step();

`ifdef SG_ARB_TURNAROUND_EN
    exp_pat = "RRRRTWTRRRTWTRR";
`else
    exp_pat = "RRRRWRRRRWRRRRW";
`endif
    applyStimulus(1'b1, 16'h40, 1'b1, 16'h41, 12'h123);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      code = rd_ack ? "R" : (wr_ack ? "W" : "T");
      checkOutput($sformatf("starve_pattern_%0d", c), code, exp_pat[c]);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (6) step();

    applyStimulus(1'b1, 16'h50, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("midrst_ack0", rd_ack, 1);
    step();
    applyStimulus(1'b1, 16'h51, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("midrst_ack1", rd_ack, 1);
    step();
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    reset_n = 1'b0;
    step();
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_valid", rd_data_valid, 0);
      step();
    end

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      saw_r = rd_ack;
      saw_w = wr_ack;
      step();
      if (!rd_req || saw_r || $urandom_range(0, 15) == 0) begin
        rd_req  = ($urandom_range(0, 3) != 0);
        rd_addr = AW'($urandom);
      end
      if (!wr_req || saw_w || $urandom_range(0, 15) == 0) begin
        wr_req  = ($urandom_range(0, 1) != 0);
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      reset_n = ($urandom_range(0, 299) != 0);
    end
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
